regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the 8x8 processor register file: N registers of W bits, two asynchronous read ports and one synchronous write port.
- The top register optionally mirrors PC (link register).
- Adds a per-register busy scoreboard for multicycle producers, plus optional write-to-read bypass.
- Sits between decode (A1/A2 reads, reservations) and writeback (A3/data) in the datapath.

Parameters:
- W, 8, data width in bits.
- N, 8, register count (power of 2, ≥4); AW = clog2(N).
- PC_LINK, 1, 1: register N-1 loads PC every cycle and ignores writes; 0: register N-1 is ordinary.
- BYPASS, 1, 1: a same-cycle write to a read address is forwarded to RD; 0: reads return the stored value only.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- WE  in  1  write enable
- A1  in  AW  read address, port 1
- A2  in  AW  read address, port 2
- A3  in  AW  write address
- data  in  W  write data
- PC  in  W  program counter, source for the link register
- RS_EN  in  1  reserve request: mark RS_A busy
- RS_A  in  AW  register to reserve
- RD1  out  W  read data, port 1 (combinational)
- RD2  out  W  read data, port 2 (combinational)
- BUSY1  out  1  A1 has a pending write
- BUSY2  out  1  A2 has a pending write
- RS_ACK  out  1  reservation accepted this cycle (combinational)
- NPEND  out  clog2(N+1)  count of busy registers (registered)

Behaviour:
- Reset (reset==0 at posedge): all registers, including N-1, go to 0; all busy bits to 0; NPEND to 0. Reset overrides WE, RS_EN and the PC load. Reset mid-reservation discards every pending reservation.
- Read: RDk = reg[Ak], combinational, zero-latency.
  - BYPASS=1 and WE and A3==Ak and Ak is writable: RDk = data.
  - With PC_LINK=1, reading N-1 returns the PC captured at the previous edge; it is never bypassed.
- Write: at posedge, if WE and A3 is writable, reg[A3] <= data.
  - Writable = !(PC_LINK && A3==N-1).
  - A write to an unwritable address has no effect and clears no busy bit.
- Link register: PC_LINK=1 loads reg[N-1] <= PC every non-reset edge, independent of WE.
- Scoreboard:
  - RS_ACK = RS_EN && !busy[RS_A] && RS_A writable.
  - Refused cases (RS_ACK=0) change no state: already busy (WAW guard), or link register.
  - Next state per address i: if RS_ACK and RS_A==i, busy[i] <= 1. Else if WE and A3==i, busy[i] <= 0. Else hold.
  - Simultaneous write and reservation to the same address: the write updates data and the reservation wins (busy=1 after the edge). RS_ACK is evaluated on pre-edge busy.
  - Writes to non-busy registers are legal and leave busy at 0.
- BUSYk = busy[Ak]. With BYPASS=1, BUSYk is forced to 0 when WE && A3==Ak (data is forwarded), except when RS_ACK targets the same address in the same cycle; then BUSYk reflects the old bit.
- NPEND: +1 on a set, -1 on a clear, net 0 when both happen on different addresses in one cycle. Always equals popcount(busy); never exceeds N-1 when PC_LINK=1.
- No X on any output after the first reset edge. Addresses are always in range (N is a power of 2).

Test Plan:
- Reset: hold reset=0 for 2 cycles with WE=1, A3=2, data=8'h55, PC=8'h10 → all RD=0, NPEND=0, BUSY1/2=0. Release → next edge reg7=8'h10.
- Write/read and bypass: WE=1, A3=3, data=8'hA1, A1=3 → RD1=8'hA1 in the same cycle (BYPASS=1) and after the edge. With BYPASS=0, RD1=0 before the edge and 8'hA1 after.
- Link register: WE=1, A3=7, data=8'hFF, PC=8'h42 → after the edge reg7=8'h42, not 8'hFF. RS_EN=1, RS_A=7 → RS_ACK=0, NPEND unchanged.
- Scoreboard lifecycle: reserve r2 → RS_ACK=1, then NPEND=1 and BUSY1=1 (A1=2). Second reserve of r2 → RS_ACK=0. WE to r2 with data=8'h32 → BUSY1=0 in that cycle (bypass) and RD1=8'h32; after the edge NPEND=0.
- Simultaneous events: busy r4 cleared by a write while r5 is reserved in the same cycle → NPEND unchanged, busy4=0, busy5=1. Write plus reserve to r1 in one cycle → reg1 updated, busy1=1, NPEND+1.
- Reset mid-operation: reserve r1, r2, r3 (NPEND=3), assert reset for one cycle → NPEND=0, all BUSY=0, all registers 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// N x W register file with two async read ports, one write port, optional PC link
// register in slot N-1, and a per-register busy scoreboard for multicycle producers.

module regfile_scoreboard_cell #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         set,
  input  logic         clr,
  output logic [W-1:0] val_q,
  output logic         busy_q
);
  logic [W-1:0] val_d;
  logic         busy_d;

  always_comb begin
    val_d  = ld ? ld_val : val_q;
    busy_d = busy_q;
    // A reservation beats a same-cycle write; the write still lands its data.
    if (set)      busy_d = 1'b1;
    else if (clr) busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      val_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
    end
  end
endmodule

module regfile_scoreboard #(
  parameter int W       = 8,
  parameter int N       = 8,
  parameter int PC_LINK = 1,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(N),
  localparam int CW     = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WE,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  input  logic [AW-1:0] A3,
  input  logic [W-1:0]  data,
  input  logic [W-1:0]  PC,
  input  logic          RS_EN,
  input  logic [AW-1:0] RS_A,
  output logic [W-1:0]  RD1,
  output logic [W-1:0]  RD2,
  output logic          BUSY1,
  output logic          BUSY2,
  output logic          RS_ACK,
  output logic [CW-1:0] NPEND
);
  localparam logic [AW-1:0] LINK_A = AW'(N-1);

  logic [N-1:0][W-1:0] regs;
  logic [N-1:0]        busy;
  logic [N-1:0]        ld, set, clr;
  logic [N-1:0][W-1:0] ld_val;
  logic                wr_ok, clr_hit;
  logic [CW-1:0]       npend_d, npend_q;

  function automatic logic writable(input logic [AW-1:0] a);
    return !((PC_LINK != 0) && (a == LINK_A));
  endfunction

  always_comb begin
    wr_ok   = WE && writable(A3);
    RS_ACK  = RS_EN && !busy[RS_A] && writable(RS_A);
    clr_hit = wr_ok && busy[A3];
    npend_d = npend_q + CW'(RS_ACK) - CW'(clr_hit);
  end

  for (genvar i = 0; i < N; i++) begin : g_reg
    localparam bit LINK = (PC_LINK != 0) && (i == N-1);
    always_comb begin
      ld[i]     = LINK ? 1'b1 : (wr_ok && A3 == AW'(i));
      ld_val[i] = LINK ? PC : data;
      set[i]    = RS_ACK && RS_A == AW'(i);
      clr[i]    = wr_ok && A3 == AW'(i);
    end
    regfile_scoreboard_cell #(.W(W)) u_cell (
      .clk    (clk),
      .reset  (reset),
      .ld     (ld[i]),
      .ld_val (ld_val[i]),
      .set    (set[i]),
      .clr    (clr[i]),
      .val_q  (regs[i]),
      .busy_q (busy[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) npend_q <= '0;
    else        npend_q <= npend_d;
  end

  // wr_ok is never true for the link register, so it is never bypassed.
  always_comb begin
    RD1   = regs[A1];
    RD2   = regs[A2];
    BUSY1 = busy[A1];
    BUSY2 = busy[A2];
    if (BYPASS != 0) begin
      if (wr_ok && A3 == A1) RD1 = data;
      if (wr_ok && A3 == A2) RD2 = data;
      if (WE && A3 == A1 && !(RS_ACK && RS_A == A1)) BUSY1 = 1'b0;
      if (WE && A3 == A2 && !(RS_ACK && RS_A == A2)) BUSY2 = 1'b0;
    end
    NPEND = npend_q;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default instance plus a BYPASS=0 twin on the same inputs.

module tb_regfile_scoreboard;
  logic       clk = 1'b0;
  logic       reset, WE, RS_EN;
  logic [2:0] A1, A2, A3, RS_A;
  logic [7:0] data, PC;
  logic [7:0] RD1, RD2, nb_rd1, nb_rd2;
  logic       BUSY1, BUSY2, RS_ACK, nb_busy1, nb_busy2, nb_ack;
  logic [3:0] NPEND, nb_npend;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard u_dut (
    .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .data(data), .PC(PC),
    .RS_EN(RS_EN), .RS_A(RS_A), .RD1(RD1), .RD2(RD2), .BUSY1(BUSY1), .BUSY2(BUSY2),
    .RS_ACK(RS_ACK), .NPEND(NPEND));

  regfile_scoreboard #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .data(data), .PC(PC),
    .RS_EN(RS_EN), .RS_A(RS_A), .RD1(nb_rd1), .RD2(nb_rd2), .BUSY1(nb_busy1), .BUSY2(nb_busy2),
    .RS_ACK(nb_ack), .NPEND(nb_npend));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; RS_EN = 1'b0;
  endtask

  initial begin
    reset = 1'b0; WE = 1'b1; A3 = 3'd2; data = 8'h55; PC = 8'h10;
    A1 = 3'd7; A2 = 3'd0; RS_EN = 1'b0; RS_A = 3'd0;
    tick(); tick();
    // still in reset: write of 0x55 to r2 must have been overridden
    idle(); A1 = 3'd2; A2 = 3'd7; #1;
    chk("rst_rd1", RD1, 8'h00);
    chk("rst_rd2", RD2, 8'h00);
    chk("rst_npend", NPEND, 0);
    chk("rst_busy1", BUSY1, 0);
    chk("rst_busy2", BUSY2, 0);
    reset = 1'b1;
    tick();
    chk("link_after_rst", RD2, 8'h10);

    // write/read with and without bypass
    WE = 1'b1; A3 = 3'd3; data = 8'hA1; A1 = 3'd3; #1;
    chk("bypass_rd1", RD1, 8'hA1);
    chk("nobypass_rd1_pre", nb_rd1, 8'h00);
    tick(); idle(); #1;
    chk("wr_rd1_post", RD1, 8'hA1);
    chk("nobypass_rd1_post", nb_rd1, 8'hA1);

    // link register ignores writes and loads PC
    WE = 1'b1; A3 = 3'd7; data = 8'hFF; PC = 8'h42; A2 = 3'd7; #1;
    chk("link_no_bypass", RD2, 8'h10);
    tick(); idle(); #1;
    chk("link_pc", RD2, 8'h42);
    RS_EN = 1'b1; RS_A = 3'd7; #1;
    chk("link_rs_ack", RS_ACK, 0);
    tick(); idle(); #1;
    chk("link_rs_npend", NPEND, 0);
    chk("link_rs_busy", BUSY2, 0);

    // scoreboard lifecycle on r2
    RS_EN = 1'b1; RS_A = 3'd2; A1 = 3'd2; #1;
    chk("rs2_ack", RS_ACK, 1);
    tick(); #1;
    chk("rs2_npend", NPEND, 1);
    chk("rs2_busy1", BUSY1, 1);
    chk("rs2_waw_ack", RS_ACK, 0);
    tick(); idle(); #1;
    chk("rs2_waw_npend", NPEND, 1);
    WE = 1'b1; A3 = 3'd2; data = 8'h32; #1;
    chk("wb2_busy1_bypass", BUSY1, 0);
    chk("wb2_busy1_nobypass", nb_busy1, 1);
    chk("wb2_rd1", RD1, 8'h32);
    tick(); idle(); #1;
    chk("wb2_npend", NPEND, 0);
    chk("wb2_busy1_post", BUSY1, 0);

    // clear r4 while reserving r5
    RS_EN = 1'b1; RS_A = 3'd4;
    tick(); idle(); #1;
    chk("rs4_npend", NPEND, 1);
    WE = 1'b1; A3 = 3'd4; data = 8'h44; RS_EN = 1'b1; RS_A = 3'd5; A1 = 3'd4; A2 = 3'd5; #1;
    chk("rs5_ack", RS_ACK, 1);
    tick(); idle(); #1;
    chk("sim_npend", NPEND, 1);
    chk("sim_busy4", BUSY1, 0);
    chk("sim_busy5", BUSY2, 1);
    chk("sim_rd4", RD1, 8'h44);

    // write plus reserve on r1 in one cycle
    WE = 1'b1; A3 = 3'd1; data = 8'h11; RS_EN = 1'b1; RS_A = 3'd1; A1 = 3'd1; #1;
    chk("wr_rs1_ack", RS_ACK, 1);
    chk("wr_rs1_busy_old", BUSY1, 0);
    chk("wr_rs1_rd1", RD1, 8'h11);
    tick(); idle(); #1;
    chk("wr_rs1_npend", NPEND, 2);
    chk("wr_rs1_busy", BUSY1, 1);
    chk("wr_rs1_rd_post", RD1, 8'h11);

    // more reservations, then reset mid-operation
    RS_EN = 1'b1; RS_A = 3'd2; tick();
    RS_A = 3'd3; tick(); idle(); #1;
    chk("pre_rst_npend", NPEND, 4);
    reset = 1'b0; A2 = 3'd3;
    tick(); #1;
    chk("mid_rst_npend", NPEND, 0);
    chk("mid_rst_busy1", BUSY1, 0);
    chk("mid_rst_busy2", BUSY2, 0);
    chk("mid_rst_rd1", RD1, 8'h00);
    A2 = 3'd7; #1;
    chk("mid_rst_link", RD2, 8'h00);
    reset = 1'b1;
    tick();
    chk("post_rst_link", RD2, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
